reg_file_2r1w: RTL
==================

Name: reg_file_2r1w

Overview:
- Parametrised general-purpose register file for the multicycle datapath; the successor to the single 32-bit enable register.
- One write port with per-byte enables and two independently addressed read ports.
- Read data is registered, so each read port also acts as the A/B latch stage.
- Optional hardwired-zero register 0 and optional write-to-read bypass.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 16, number of registers; need not be a power of 2.
- ADDR_W, clog2(DEPTH) (min 1), address width.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns the merged new value.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  WIDTH  write data
- wr_be  in  WIDTH/8  byte enables; bit i covers bits [8i+7:8i]
- rd_en  in  1  load enable shared by both read output registers
- ra_addr  in  ADDR_W  read port A address
- rb_addr  in  ADDR_W  read port B address
- rd_data_a  out  WIDTH  registered read data A
- rd_data_b  out  WIDTH  registered read data B

Behaviour:
- Reset is asynchronous and active-high: while reset=1, every storage register, rd_data_a and rd_data_b are 0.
- Clock edges are ignored while reset is high. A write or read coincident with reset assertion is lost.
- Write:
  - Occurs at a rising clk edge when wr_en=1 and the write is valid.
  - Valid means wr_addr < DEPTH and not (ZERO_REG=1 and wr_addr=0).
  - Only the bytes with wr_be=1 are updated; the other bytes keep their value.
  - wr_be=0 with wr_en=1 changes nothing.
- Invalid write: silently dropped, with no side effects.
- Read:
  - At a rising edge with rd_en=1, rd_data_a loads the value at ra_addr and rd_data_b loads the value at rb_addr.
  - Latency is 1 cycle: the output is valid after the edge where rd_en was sampled.
  - With rd_en=0 both outputs hold their value.
- Read value rules:
  - An address >= DEPTH reads 0.
  - Register 0 reads 0 when ZERO_REG=1.
- Simultaneous write and read of the same address on the same edge:
  - BYPASS=1: the read returns the stored word with the enabled bytes replaced by wr_data, i.e. the post-write value.
  - BYPASS=0: the read returns the pre-write value.
  - The bypass applies only to valid writes. Both ports may bypass at once.
- ra_addr may equal rb_addr; both ports then return identical data.
- There is no combinational path from any input to rd_data_a or rd_data_b.

Decomposition:
- Package reg_file_pkg holds:
  - function clog2_min1(depth)
  - function byte_merge(old, new, be), parametrised by WIDTH
  - localparam BYTE_W = 8
- Sub-module reg_file_read_port:
  - Contains the address range/zero check, bypass mux and output register with rd_en.
  - Instantiated twice, for ports A and B.
- The storage array and write logic stay in the top module.

Test Plan:
1. Reset and zero register:
   - Assert reset mid-run after writes, then deassert → both outputs 0 immediately, and every address reads 0.
   - Write 0xDEADBEEF to reg 0 with ZERO_REG=1, then read → 0x00000000.
2. Basic write/read:
   - Write 0x12345678 to r5 (wr_be=4'hF); next cycle read ra=5, rb=5 with rd_en=1 → both 0x12345678 one cycle later.
   - Hold rd_en=0 → the outputs keep that value.
3. Byte enables:
   - r3 holds 0xAABBCCDD; write 0x11223344 with wr_be=4'b0101 → r3 = 0xAA22CC44.
4. Bypass, same-edge write to r7 (old value 0x0000FFFF) of 0xFFFF0000 with wr_be=4'b1100, read ra=7:
   - BYPASS=1 → rd_data_a = 0xFFFFFFFF.
   - BYPASS=0 → rd_data_a = 0x0000FFFF; a subsequent read returns 0xFFFFFFFF.
5. Out-of-range address with DEPTH=12:
   - Write 0xCAFEF00D to address 13 → no register changes.
   - Read address 13 → 0.
   - Read address 11 after writing it → correct value.
6. Dual-port independence:
   - Load r1=0x1, r2=0x2; read ra=1, rb=2 → rd_data_a=0x1, rd_data_b=0x2 on the same cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared helpers for the 2-read/1-write register file: address sizing and
// byte-lane merging used by both the write path and the read bypass.
package reg_file_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_WIDTH = 256;
  localparam int MAX_BYTES = MAX_WIDTH / BYTE_W;

  function automatic int clog2_min1(input int depth);
    int w;
    w = 1;
    while ((32'sd1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Callers zero-extend into MAX_WIDTH and truncate the result back to WIDTH.
  function automatic logic [MAX_WIDTH-1:0] byte_merge(
    input logic [MAX_WIDTH-1:0] oldWord,
    input logic [MAX_WIDTH-1:0] newWord,
    input logic [MAX_BYTES-1:0] be,
    input int                   width
  );
    logic [MAX_WIDTH-1:0] merged;
    merged = oldWord;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (be[i] && (i < (width / BYTE_W))) begin
        merged[i*BYTE_W +: BYTE_W] = newWord[i*BYTE_W +: BYTE_W];
      end else begin
        merged[i*BYTE_W +: BYTE_W] = oldWord[i*BYTE_W +: BYTE_W];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Bus bundle for the register file: one byte-enabled write port and two
// read ports sharing a load enable.
interface reg_file_2r1w_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = clog2_min1(DEPTH)
);

  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic [WIDTH/BYTE_W-1:0]   wr_be;
  logic                      rd_en;
  logic [ADDR_W-1:0]         ra_addr;
  logic [ADDR_W-1:0]         rb_addr;
  logic [WIDTH-1:0]          rd_data_a;
  logic [WIDTH-1:0]          rd_data_b;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, ra_addr, rb_addr,
    input  rd_data_a, rd_data_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, ra_addr, rb_addr,
    output rd_data_a, rd_data_b
  );

endinterface

// File: rtl/reg_file_read_port.sv
// One registered read port: range/zero-register masking, same-edge write
// bypass, and the output latch that doubles as the A/B operand register.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = clog2_min1(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rdEn,
  input  logic [ADDR_W-1:0]            rdAddr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
  input  logic                         wrValid,
  input  logic [ADDR_W-1:0]            wrAddr,
  input  logic [WIDTH-1:0]             wrWord,
  output logic [WIDTH-1:0]             rdData
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] nextData;

  // Select the word to load: masked, bypassed from the write port, or stored.
  always_comb begin
    nextData = '0;
    if (({1'b0, rdAddr} >= DEPTH_LIM) || ((ZERO_REG != 0) && (rdAddr == '0))) begin
      nextData = '0;
    end else if ((BYPASS != 0) && wrValid && (wrAddr == rdAddr)) begin
      nextData = wrWord;
    end else begin
      nextData = regs[rdAddr];
    end
  end

  // Output register; holds while rdEn is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdData <= '0;
    end else if (rdEn) begin
      rdData <= nextData;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised general-purpose register file: storage and byte-enabled write
// path here, two registered read ports instantiated from reg_file_read_port.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = clog2_min1(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  reg_file_2r1w_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic                        wrValid;
  logic [WIDTH-1:0]            oldWord;
  logic [WIDTH-1:0]            mergedWord;

  // Qualify the write and build the post-write word, shared with the bypass.
  always_comb begin
    wrValid = 1'b0;
    oldWord = '0;
    if (bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_LIM) &&
        !((ZERO_REG != 0) && (bus.wr_addr == '0))) begin
      wrValid = 1'b1;
      oldWord = regs[bus.wr_addr];
    end else begin
      wrValid = 1'b0;
      oldWord = '0;
    end
    mergedWord = WIDTH'(byte_merge(MAX_WIDTH'(oldWord), MAX_WIDTH'(bus.wr_data),
                                   MAX_BYTES'(bus.wr_be), WIDTH));
  end

  // Storage array; register 0 is never written when it is hardwired to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (wrValid) begin
      regs[bus.wr_addr] <= mergedWord;
    end
  end

  reg_file_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) portA (
    .clk(clk), .reset(reset), .rdEn(bus.rd_en), .rdAddr(bus.ra_addr),
    .regs(regs), .wrValid(wrValid), .wrAddr(bus.wr_addr), .wrWord(mergedWord),
    .rdData(bus.rd_data_a)
  );

  reg_file_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) portB (
    .clk(clk), .reset(reset), .rdEn(bus.rd_en), .rdAddr(bus.rb_addr),
    .regs(regs), .wrValid(wrValid), .wrAddr(bus.wr_addr), .wrWord(mergedWord),
    .rdData(bus.rd_data_b)
  );

endmodule
